// File: rtl/aes_result_reader_if.sv
// Bus between the AES result reader and its surroundings: result capture, user controls, LED view.
// Master drives result/controls and observes the display; the reader itself is the slave.
interface aes_result_reader_if #(
    parameter int DATA_W = 128
);
    logic [DATA_W-1:0] res_data;
    logic              res_valid;
    logic              next_btn;
    logic              prev_btn;
    logic              nib_sel;
    logic              clear;
    logic [3:0]        led_data;
    logic [3:0]        byte_idx;
    logic              captured;
    logic              wrap;

    modport master (
        output res_data, res_valid, next_btn, prev_btn, nib_sel, clear,
        input  led_data, byte_idx, captured, wrap
    );

    modport slave (
        input  res_data, res_valid, next_btn, prev_btn, nib_sel, clear,
        output led_data, byte_idx, captured, wrap
    );
endinterface

// File: rtl/aes_result_reader.sv
// Captures a 128-bit AES result and shows it one nibble at a time; AES_READER_AUTOSCROLL_EN adds auto-advance.
// Latency: res_valid -> captured/byte_idx +1, led_data +2; raw button rise -> byte_idx +3, led_data +4.
// Backpressure: none; res_valid is always accepted unless clear is high in the same cycle.
module aes_result_reader #(
    parameter int DATA_W = 128
`ifdef AES_READER_AUTOSCROLL_EN
    ,
    parameter int SCROLL_TICKS = 125000000
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    aes_result_reader_if.slave bus
);
    typedef enum logic {
        S_EMPTY = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] buf_q;
    logic [3:0]        byte_idx_q;
    logic [3:0]        led_data_q;
    logic              captured_q;
    logic              wrap_q;

    // [0],[1] form the synchronizer, [2] holds the previous synchronized level for edge detection
    logic [2:0] next_sync_q;
    logic [2:0] prev_sync_q;

    logic       next_edge;
    logic       prev_edge;
    logic       auto_step;
    logic       step_fwd;
    logic       step_back;
    logic [7:0] buf_bytes [16];
    logic [7:0] byte_sel;
    logic [3:0] led_data_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            next_sync_q <= '0;
            prev_sync_q <= '0;
        end else begin
            next_sync_q <= {next_sync_q[1:0], bus.next_btn};
            prev_sync_q <= {prev_sync_q[1:0], bus.prev_btn};
        end
    end

    assign next_edge = next_sync_q[1] & ~next_sync_q[2];
    assign prev_edge = prev_sync_q[1] & ~prev_sync_q[2];

`ifdef AES_READER_AUTOSCROLL_EN
    localparam int CNT_W = (SCROLL_TICKS > 1) ? $clog2(SCROLL_TICKS) : 1;

    logic [CNT_W-1:0] scroll_q;

    // Any manual edge, even a cancelled next+prev pair, restarts the auto-advance interval
    assign auto_step = (state_q == S_HOLD) && (scroll_q == CNT_W'(SCROLL_TICKS - 1))
                       && !next_edge && !prev_edge;

    always_ff @(posedge clk) begin
        if (!rst_n || state_q == S_EMPTY || bus.clear || bus.res_valid
            || next_edge || prev_edge || auto_step) begin
            scroll_q <= '0;
        end else begin
            scroll_q <= scroll_q + 1'b1;
        end
    end
`else
    assign auto_step = 1'b0;
`endif

    assign step_fwd  = (next_edge & ~prev_edge) | auto_step;
    assign step_back = prev_edge & ~next_edge;

    // Byte 0 is the most significant byte, matching the load ordering
    for (genvar g = 0; g < 16; g++) begin : g_bytes
        assign buf_bytes[g] = buf_q[DATA_W-1-8*g -: 8];
    end

    assign byte_sel   = buf_bytes[byte_idx_q];
    assign led_data_d = (state_q == S_HOLD) ? (bus.nib_sel ? byte_sel[7:4] : byte_sel[3:0]) : 4'h0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_EMPTY;
            buf_q      <= '0;
            byte_idx_q <= '0;
            led_data_q <= '0;
            captured_q <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            wrap_q     <= 1'b0;
            led_data_q <= led_data_d;
            if (bus.clear) begin
                state_q    <= S_EMPTY;
                buf_q      <= '0;
                byte_idx_q <= '0;
                captured_q <= 1'b0;
            end else if (bus.res_valid) begin
                state_q    <= S_HOLD;
                buf_q      <= bus.res_data;
                byte_idx_q <= '0;
                captured_q <= 1'b1;
            end else if (state_q == S_HOLD) begin
                if (step_fwd) begin
                    byte_idx_q <= byte_idx_q + 4'd1;
                    wrap_q     <= (byte_idx_q == 4'hF);
                end else if (step_back) begin
                    byte_idx_q <= byte_idx_q - 4'd1;
                    wrap_q     <= (byte_idx_q == 4'h0);
                end
            end
        end
    end

    assign bus.led_data = led_data_q;
    assign bus.byte_idx = byte_idx_q;
    assign bus.captured = captured_q;
    assign bus.wrap     = wrap_q;
endmodule
